// File: rtl/snn_input_packet_encoder.sv
//==============================================================================
// Module   : snn_input_packet_encoder
// Brief    : Builds 45-bit filter-row / ifmap-chunk / PE-ack packets for the
//            instruction decoder, with acks taking priority on every load.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module snn_input_packet_encoder #(
    parameter int WIDTH        = 45,
    parameter int FILTER_WIDTH = 8,
    parameter int IF_CHUNK     = 36
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [1:0]                cfg_filter_size,
    input  logic [5:0]                cfg_ifmap_size,
    input  logic                      fil_valid,
    output logic                      fil_ready,
    input  logic [5*FILTER_WIDTH-1:0] fil_data,
    input  logic                      if_valid,
    output logic                      if_ready,
    input  logic [IF_CHUNK-1:0]       if_data,
    input  logic                      ack_valid,
    output logic                      ack_ready,
    input  logic [3:0]                ack_pe,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [WIDTH-1:0]          pkt_data,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FILTER = 3'd1,
        S_IF_T0  = 3'd2,
        S_IF_T1  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t             r_state;
    logic [1:0]         r_fsize;
    logic [1:0]         r_row;
    logic [5:0]         r_nsize;
    logic [6:0]         r_chunks;
    logic [6:0]         r_chunk;
    logic               r_pkt_valid;
    logic [WIDTH-1:0]   r_pkt_data;
    logic               r_busy;
    logic               r_done;

    logic [11:0]        w_npix;
    logic [11:0]        w_chunks_wide;
    logic               w_load;
    logic               w_in_if;
    logic               w_ack_go;
    logic               w_fil_go;
    logic               w_if_go;
    logic [WIDTH-1:0]   w_ack_pkt;
    logic [WIDTH-1:0]   w_fil_pkt;
    logic [WIDTH-1:0]   w_if_pkt;

    // Chunk count is derived straight from the config inputs so it can be latched on accept.
    assign w_npix        = {6'd0, cfg_ifmap_size} * {6'd0, cfg_ifmap_size};
    assign w_chunks_wide = (w_npix + 12'(IF_CHUNK - 1)) / 12'(IF_CHUNK);

    assign w_load   = !r_pkt_valid || pkt_ready;
    assign w_in_if  = (r_state == S_IF_T0) || (r_state == S_IF_T1);

    assign cfg_ready = (r_state == S_IDLE);
    assign ack_ready = w_load && !rst;
    assign fil_ready = (r_state == S_FILTER) && w_load && !ack_valid;
    assign if_ready  = w_in_if && w_load && !ack_valid;

    assign w_ack_go = ack_valid && ack_ready;
    assign w_fil_go = fil_valid && fil_ready;
    assign w_if_go  = if_valid && if_ready;

    assign w_ack_pkt = {{(WIDTH-5){1'b0}}, ack_pe, 1'b0};
    assign w_fil_pkt = {fil_data, r_fsize, 3'b011};
    assign w_if_pkt  = {if_data, r_nsize, (r_state == S_IF_T1), 2'b01};

    assign pkt_valid = r_pkt_valid;
    assign pkt_data  = r_pkt_data;
    assign busy      = r_busy;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_fsize     <= 2'd0;
            r_row       <= 2'd0;
            r_nsize     <= 6'd0;
            r_chunks    <= 7'd0;
            r_chunk     <= 7'd0;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (w_ack_go) begin
                r_pkt_valid <= 1'b1;
                r_pkt_data  <= w_ack_pkt;
            end else if (w_fil_go) begin
                r_pkt_valid <= 1'b1;
                r_pkt_data  <= w_fil_pkt;
            end else if (w_if_go) begin
                r_pkt_valid <= 1'b1;
                r_pkt_data  <= w_if_pkt;
            end else if (pkt_ready) begin
                r_pkt_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        r_fsize  <= cfg_filter_size;
                        r_nsize  <= cfg_ifmap_size;
                        r_chunks <= 7'(w_chunks_wide);
                        r_row    <= 2'd0;
                        r_chunk  <= 7'd0;
                        r_busy   <= 1'b1;
                        if (cfg_filter_size != 2'd0)
                            r_state <= S_FILTER;
                        else if (cfg_ifmap_size != 6'd0)
                            r_state <= S_IF_T0;
                        else
                            r_state <= S_FINISH;
                    end
                end
                S_FILTER: begin
                    if (w_fil_go) begin
                        if (r_row == r_fsize - 2'd1) begin
                            r_row   <= 2'd0;
                            r_state <= (r_nsize != 6'd0) ? S_IF_T0 : S_FINISH;
                        end else begin
                            r_row <= r_row + 2'd1;
                        end
                    end
                end
                S_IF_T0, S_IF_T1: begin
                    if (w_if_go) begin
                        if (r_chunk == r_chunks - 7'd1) begin
                            r_chunk <= 7'd0;
                            r_state <= (r_state == S_IF_T0) ? S_IF_T1 : S_FINISH;
                        end else begin
                            r_chunk <= r_chunk + 7'd1;
                        end
                    end
                end
                S_FINISH: begin
                    // Leave only once the last stream packet has been taken and no ack refills the register.
                    if (w_load && !w_ack_go) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/snn_input_packet_encoder.md
Name: snn_input_packet_encoder

Overview:
- Host-side transmitter that builds the 45-bit input packets consumed by the instruction decoder.
- Packet types: filter-row, ifmap-chunk and PE-ack.
- Takes one layer config plus streams of filter rows, ifmap chunks and PE ack requests.
- Sequences them as filter rows, then ifmap timestep 0, then ifmap timestep 1, with acks interleaved at priority.
- Sits between the host/testbench stimulus and the decoder input channel; one clock domain, valid/ready on every interface.

Parameters:
- WIDTH, 45, output packet width.
- FILTER_WIDTH, 8, bits per filter weight; filter row payload is 5*FILTER_WIDTH = 40 bits.
- IF_CHUNK, 36, ifmap pixels (bits) per ifmap packet.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- cfg_valid  in  1  layer config offered.
- cfg_ready  out  1  config accepted (high only in IDLE).
- cfg_filter_size  in  2  filter rows/size (3 = 3x3); 0 = no filter phase.
- cfg_ifmap_size  in  6  ifmap edge size N; 0 = no ifmap phase.
- fil_valid/fil_ready  in/out  1/1  filter row handshake.
- fil_data  in  40  filter row {0s, w2, w1, w0}.
- if_valid/if_ready  in/out  1/1  ifmap chunk handshake.
- if_data  in  36  ifmap chunk.
- ack_valid/ack_ready  in/out  1/1  PE ack request handshake.
- ack_pe  in  4  PE node id 0..13.
- pkt_valid/pkt_ready  out/in  1/1  output packet handshake.
- pkt_data  out  45  output packet.
- busy  out  1  high from config accept until done.
- done  out  1  one-cycle pulse when the last ifmap t1 packet is accepted downstream.

Behaviour:
- Reset (async, immediate): state IDLE; all counters 0; pkt_valid=0, pkt_data=0, busy=0, done=0; all *_ready=0 except cfg_ready=1.
- A reset mid-layer discards any packet in flight with no partial output.
- FSM states: IDLE -> FILTER -> IF_T0 -> IF_T1 -> FINISH -> IDLE.
- Config handshake in IDLE latches the sizes and sets busy.
- chunks = ceil(N*N/36), computed in 12-bit arithmetic, 7-bit result; max N=63 gives 111.
- A zero-size phase is skipped in 0 cycles of output.
- If both sizes are 0, go straight to FINISH: done pulses the cycle after config accept.
- Output register:
  - pkt_data/pkt_valid are registered.
  - The register loads when empty or when pkt_valid && pkt_ready in the same cycle, so throughput is 1 packet/cycle under continuous ready.
  - pkt_data holds stable while pkt_valid && !pkt_ready.
  - An input handshake completes only in a cycle the register loads.
- Arbitration on each load: ack_valid wins over the stream input in every state, including IDLE and FINISH.
  - Ack packet = {40'b0, ack_pe, 1'b0}.
  - Otherwise load from the current phase stream.
- Filter packet = {fil_data, filter_size[1:0], 1'b0, 1'b1, 1'b1}.
  - Row counter increments per accepted row.
  - Move to the next phase after row filter_size-1.
- Ifmap packet = {if_data, N[5:0], ts, 1'b0, 1'b1}, with ts=0 in IF_T0 and ts=1 in IF_T1.
  - Chunk counter increments per accepted chunk and wraps to 0 after chunks-1.
  - IF_T0 -> IF_T1 on wrap; IF_T1 -> FINISH on wrap.
- Latency: input handshake to pkt_valid = 1 cycle.
- Only one of fil_ready/if_ready is high at a time, and only in its own phase.
- FINISH waits for the output register to drain, pulses done, then returns to IDLE.
- cfg_ready is low whenever busy.
- Simultaneous ack and stream valid: the ack is sent, and the stream word waits with ready low.

Test Plan:
- Filter 3, N=6, pkt_ready=1:
  - Output 3 filter packets with low bits 0x1B.
  - Then 1 packet with low 9 bits 0x031 (t0), then 1 with 0x035 (t1).
  - done pulses once; busy falls the same cycle.
- N=13 (169 px): exactly 5 ifmap packets per timestep, 10 total; the chunk counter wraps 4->0 between timesteps.
- Ack for PE 5 asserted alongside fil_valid:
  - First packet = 45'h00000000000A.
  - The filter row follows the next cycle; fil_ready stays low during the ack cycle.
- Backpressure (pkt_ready low for 4 cycles mid-filter):
  - pkt_data holds stable; no input handshake completes.
  - Ordering is preserved after release.
- Config with filter 0, N=0: no packets emitted; done pulses the cycle after config accept.
- rst asserted during IF_T0 (chunk 2 of 5):
  - pkt_valid drops immediately; cfg_ready=1.
  - A new config restarts from row 0.
